// File: rtl/a429_tx_serializer.sv
// ARINC429 transmit bit engine: takes one 32-bit word over valid/ready, can
// replace bit 31 with odd parity, and sends the word LSB first as bipolar RZ on
// the HI/LO driver controls. After each word it holds a 4-bit-time null gap
// before it accepts the next word.
module a429_tx_serializer #(
  parameter int unsigned CLOCK_KHZ = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        spd_i,
  input  logic        par_en_i,
  input  logic [31:0] dat_i,
  input  logic        vld_i,
  output logic        rdy_o,
  output logic        txa_o,
  output logic        txb_o,
  output logic        busy_o
);

  localparam int unsigned HB_HS  = CLOCK_KHZ / 200;
  localparam int unsigned HB_LS  = 8 * HB_HS;
  localparam int unsigned GAP_HS = 8 * HB_HS;
  localparam int unsigned GAP_LS = 8 * HB_LS;
  localparam int unsigned CNT_W  = $clog2(GAP_LS);

  localparam logic [CNT_W-1:0] HB_HS_LOAD  = CNT_W'(HB_HS - 1);
  localparam logic [CNT_W-1:0] HB_LS_LOAD  = CNT_W'(HB_LS - 1);
  localparam logic [CNT_W-1:0] GAP_HS_LOAD = CNT_W'(GAP_HS - 1);
  localparam logic [CNT_W-1:0] GAP_LS_LOAD = CNT_W'(GAP_LS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BIT_ON   = 2'd1,
    BIT_NULL = 2'd2,
    GAP      = 2'd3
  } state_e;

  // Odd parity over 32 bits: bit 31 makes the total number of ones odd.
  function automatic logic odd_par(input logic [30:0] d);
    return ~(^d);
  endfunction

  state_e           state_r, state_s;
  logic [31:0]      sh_r, sh_s;
  logic             spd_r, spd_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [4:0]       bit_cnt_r, bit_cnt_s;
  logic             txa_r, txa_s;
  logic             txb_r, txb_s;
  logic             rdy_r, rdy_s;
  logic             busy_r, busy_s;
  logic [31:0]      word_s;
  logic [CNT_W-1:0] hb_load_s;
  logic [CNT_W-1:0] gap_load_s;
  logic             cnt_zero_s;
  logic             bit_last_s;

  // Next-state and next-output logic for the bit sequencer.
  always_comb begin
    state_s    = state_r;
    sh_s       = sh_r;
    spd_s      = spd_r;
    cnt_s      = cnt_r;
    bit_cnt_s  = bit_cnt_r;
    txa_s      = txa_r;
    txb_s      = txb_r;
    rdy_s      = rdy_r;
    busy_s     = busy_r;
    word_s     = 32'h0000_0000;
    hb_load_s  = spd_r ? HB_HS_LOAD : HB_LS_LOAD;
    gap_load_s = spd_r ? GAP_HS_LOAD : GAP_LS_LOAD;
    cnt_zero_s = (cnt_r == CNT_ZERO);
    bit_last_s = (bit_cnt_r == 5'd31);

    case (state_r)
      IDLE: begin
        if (vld_i && rdy_r) begin
          word_s    = {(par_en_i ? odd_par(dat_i[30:0]) : dat_i[31]), dat_i[30:0]};
          sh_s      = word_s;
          spd_s     = spd_i;
          cnt_s     = spd_i ? HB_HS_LOAD : HB_LS_LOAD;
          bit_cnt_s = 5'd0;
          txa_s     = word_s[0];
          txb_s     = ~word_s[0];
          rdy_s     = 1'b0;
          busy_s    = 1'b1;
          state_s   = BIT_ON;
        end else begin
          txa_s = 1'b0;
          txb_s = 1'b0;
        end
      end
      BIT_ON: begin
        if (cnt_zero_s) begin
          // Drop the finished bit now so the next one sits in sh_r[0].
          sh_s    = {1'b0, sh_r[31:1]};
          cnt_s   = hb_load_s;
          txa_s   = 1'b0;
          txb_s   = 1'b0;
          state_s = BIT_NULL;
        end else begin
          cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      BIT_NULL: begin
        if (cnt_zero_s) begin
          if (bit_last_s) begin
            cnt_s   = gap_load_s;
            state_s = GAP;
          end else begin
            bit_cnt_s = bit_cnt_r + 5'd1;
            cnt_s     = hb_load_s;
            txa_s     = sh_r[0];
            txb_s     = ~sh_r[0];
            state_s   = BIT_ON;
          end
        end else begin
          cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      GAP: begin
        if (cnt_zero_s) begin
          rdy_s   = 1'b1;
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        txa_s   = 1'b0;
        txb_s   = 1'b0;
        rdy_s   = 1'b1;
        busy_s  = 1'b0;
        cnt_s   = CNT_ZERO;
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered line outputs; reset forces the line to null.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r   <= IDLE;
      sh_r      <= 32'h0000_0000;
      spd_r     <= 1'b0;
      cnt_r     <= CNT_ZERO;
      bit_cnt_r <= 5'd0;
      txa_r     <= 1'b0;
      txb_r     <= 1'b0;
      rdy_r     <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      sh_r      <= sh_s;
      spd_r     <= spd_s;
      cnt_r     <= cnt_s;
      bit_cnt_r <= bit_cnt_s;
      txa_r     <= txa_s;
      txb_r     <= txb_s;
      rdy_r     <= rdy_s;
      busy_r    <= busy_s;
    end
  end

  assign txa_o  = txa_r;
  assign txb_o  = txb_r;
  assign rdy_o  = rdy_r;
  assign busy_o = busy_r;

endmodule

// File: tb/tb_a429_tx_serializer.sv
// Self-checking bench for a429_tx_serializer. The clock is scaled so that one
// half-bit is 2 cycles at high speed and 16 cycles at low speed. This keeps
// whole words short, and all timing expectations are in those units.
module tb_a429_tx_serializer;

  localparam int unsigned CLOCK_KHZ = 400;  // HB_HS = 2, HB_LS = 16

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        spd_i;
  logic        par_en_i;
  logic [31:0] dat_i;
  logic        vld_i;
  logic        rdy_o;
  logic        txa_o;
  logic        txb_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  a429_tx_serializer #(.CLOCK_KHZ(CLOCK_KHZ)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .spd_i   (spd_i),
    .par_en_i(par_en_i),
    .dat_i   (dat_i),
    .vld_i   (vld_i),
    .rdy_o   (rdy_o),
    .txa_o   (txa_o),
    .txb_o   (txb_o),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        spd;
    logic        par;
    logic [31:0] dat;
    logic [31:0] exp_word;  // word as it must appear on the line
    int          exp_len;   // accept-to-ready cycles (72 half-bits)
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Wait (bounded) at falling edges until the DUT is ready.
  task automatic wait_rdy(input int max_cycles, input string name);
    int n;
    n = 0;
    @(negedge clk_i);
    while (rdy_o !== 1'b1 && n < max_cycles) begin
      @(negedge clk_i);
      n++;
    end
    if (rdy_o !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual_rdy=%b required_rdy=1", name, rdy_o);
    end
  endtask

  // Send one word and compare every cycle of it against a timing model.
  task automatic run_word(input logic spd, input logic par, input logic [31:0] dat,
                          input logic [31:0] exp_word, input int len, input string tag);
    int hb, slot, ph, wave_err, both, rdy_at;
    logic on, bitv, e_a, e_b, e_r, e_busy;
    logic [31:0] got;
    hb = spd ? 2 : 16;
    wave_err = 0; both = 0; rdy_at = -1; got = 32'h0;
    wait_rdy(2000, {tag, "_idle"});
    spd_i = spd; par_en_i = par; dat_i = dat; vld_i = 1'b1;
    @(posedge clk_i); #1;
    vld_i = 1'b0;
    for (int k = 0; k <= len; k++) begin
      if (k > 0) begin
        @(posedge clk_i); #1;
      end
      slot   = k / (2 * hb);
      ph     = k % (2 * hb);
      on     = (k < 64 * hb) && (ph < hb);
      bitv   = (slot < 32) ? exp_word[slot] : 1'b0;
      e_a    = on & bitv;
      e_b    = on & ~bitv;
      e_r    = (k == len);
      e_busy = (k != len);
      if (txa_o !== e_a || txb_o !== e_b || rdy_o !== e_r || busy_o !== e_busy) wave_err++;
      if (txa_o === 1'b1 && txb_o === 1'b1) both++;
      if (on && ph == 0) got[slot] = txa_o;
      if (rdy_o === 1'b1 && rdy_at < 0) rdy_at = k;
      // Speed changes mid-word must be ignored; a stray valid must be ignored too.
      spd_i = ~spd_i;
      if (k == 10) begin
        vld_i = 1'b1;
        dat_i = ~dat;
      end
      if (k == 20) vld_i = 1'b0;
    end
    chk({tag, "_word"}, got, exp_word);
    chk({tag, "_wave_errs"}, wave_err, 32'd0);
    chk({tag, "_rdy_cycle"}, rdy_at, len);
    chk({tag, "_both_high"}, both, 32'd0);
  endtask

  initial begin
    int errs;
    logic [3:0] st;
    int rdy_first;
    logic rdy_a[151];
    logic txa_a[151];
    logic txb_a[151];
    int nulls;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0001, 32'h0000_0001, 144};
    vecs[1] = '{1'b0, 1'b0, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1152};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0003, 32'h8000_0003, 144};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0007, 32'h0000_0007, 144};
    vecs[4] = '{1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 144};
    vecs[5] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 144};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_0000, 32'h8000_0000, 144};
    vecs[7] = '{1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678, 144};

    rst_i = 1'b0; spd_i = 1'b1; par_en_i = 1'b0; dat_i = 32'h0; vld_i = 1'b0;

    // Reset hold and release with no valid.
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if ({txa_o, txb_o, rdy_o, busy_o} !== 4'b0010) errs++;
    end
    chk("reset_hold", errs, 32'd0);
    rst_i = 1'b1;
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if ({txa_o, txb_o, rdy_o, busy_o} !== 4'b0010) errs++;
    end
    chk("reset_release_idle", errs, 32'd0);

    // Asynchronous reset in the middle of bit 10 at high speed.
    spd_i = 1'b1; par_en_i = 1'b0; dat_i = 32'hFFFF_FFFF; vld_i = 1'b1;
    @(posedge clk_i); #1;
    vld_i = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_i); #1;
    end
    chk("midword_bit10_on", {txa_o, txb_o}, 2'b10);
    rst_i = 1'b0;
    #1;
    st = {txa_o, txb_o, rdy_o, busy_o};
    chk("async_reset_outputs", st, 4'b0010);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    errs = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if ({txa_o, txb_o, rdy_o, busy_o} !== 4'b0010) errs++;
    end
    chk("no_residue_after_reset", errs, 32'd0);

    // Table of words: each one is accepted and compared cycle by cycle.
    for (int v = 0; v < 8; v++) begin
      run_word(vecs[v].spd, vecs[v].par, vecs[v].dat, vecs[v].exp_word,
               vecs[v].exp_len, $sformatf("vec%0d", v));
    end

    // Back-to-back: valid held high, the second word follows right after the gap.
    wait_rdy(2000, "b2b_idle");
    spd_i = 1'b1; par_en_i = 1'b0; dat_i = 32'h0000_0001; vld_i = 1'b1;
    @(posedge clk_i); #1;
    dat_i = 32'h0000_0002;
    rdy_a[0] = rdy_o; txa_a[0] = txa_o; txb_a[0] = txb_o;
    for (int k = 1; k <= 150; k++) begin
      @(posedge clk_i); #1;
      rdy_a[k] = rdy_o; txa_a[k] = txa_o; txb_a[k] = txb_o;
      if (k == 145) vld_i = 1'b0;
    end
    rdy_first = -1;
    nulls = 0;
    for (int k = 0; k <= 150; k++) begin
      if (rdy_a[k] === 1'b1 && rdy_first < 0) rdy_first = k;
      if (k >= 128 && k <= 144 && txa_a[k] === 1'b0 && txb_a[k] === 1'b0) nulls++;
    end
    chk("b2b_first_word_bit0_hi", {txa_a[0], txb_a[0]}, 2'b10);
    chk("b2b_rdy_return", rdy_first, 32'd144);
    chk("b2b_gap_nulls", nulls, 32'd17);
    chk("b2b_second_accept", rdy_a[145], 1'b0);
    chk("b2b_second_first_pulse", {txa_a[145], txb_a[145]}, 2'b01);
    chk("b2b_no_early_pulse", {txa_a[144], txb_a[144]}, 2'b00);
    wait_rdy(400, "b2b_done");
    chk("final_idle", {txa_o, txb_o, rdy_o, busy_o}, 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/a429_tx_serializer.md
Name: a429_tx_serializer

Overview:
- ARINC429 transmit-side bit engine. It is the transmit counterpart of the receive line filter and sits between the TX word FIFO/register block and the external line driver.
- Accepts one 32-bit word over a valid/ready handshake and optionally inserts odd parity.
- Serializes the word as bipolar return-to-zero (RZ) on two unipolar driver controls (HI/LO), at 100 kbps or 12.5 kbps.
- Enforces the 4-bit-time minimum inter-word null gap before accepting the next word.

Parameters:
- CLOCK_KHZ, 100000: system clock frequency in kHz. Half-bit time is HB_HS = CLOCK_KHZ/200 cycles at high speed and HB_LS = 8*HB_HS at low speed. Must give HB_HS >= 2.

Ports:
- clk_i  input  1  system clock, single clock domain
- rst_i  input  1  asynchronous, active-low reset
- spd_i  input  1  1 = high speed (100 kbps), 0 = low speed (12.5 kbps); sampled only on word accept
- par_en_i  input  1  1 = replace word bit 31 with generated odd parity; sampled on accept
- dat_i  input  32  word to send; dat_i[0] (ARINC bit 1) is sent first, dat_i[31] last
- vld_i  input  1  word valid
- rdy_o  output  1  ready to accept a word
- txa_o  output  1  line HI drive (positive half-bit)
- txb_o  output  1  line LO drive (negative half-bit)
- busy_o  output  1  a word or its gap is in progress

Behaviour:
- Reset (rst_i low, asynchronous): txa_o=0, txb_o=0, rdy_o=1, busy_o=0, state=IDLE, all counters 0. A reset mid-word drops the line to null immediately and discards the word; there is no partial completion after release.
- Handshake: a word is accepted on a rising edge where vld_i && rdy_o.
  - On the accept edge: latch shift register, speed and parity enable; rdy_o goes 0 and busy_o goes 1 on the same edge.
  - vld_i while rdy_o=0 is ignored; the word must be held by the source.
- Parity: when par_en_i=1, latched bit31 = ~^dat_i[30:0], giving odd parity over 32 bits. When par_en_i=0, bit31 passes through unchanged.
- Half-bit counter: loaded with HB-1 (HB_HS or HB_LS per the latched speed). It decrements each cycle; a phase ends on the cycle it reads 0. spd_i changes mid-word have no effect.
- FSM:
  - IDLE: line null; rdy_o=1. On accept go to BIT_ON, with txa_o/txb_o driven from bit0 registered on the accept edge. Line activity therefore starts 1 cycle after accept, i.e. visible in the first cycle after the edge.
  - BIT_ON (HB cycles): bit=1 gives txa_o=1, txb_o=0; bit=0 gives txa_o=0, txb_o=1. At end go to BIT_NULL with both outputs 0.
  - BIT_NULL (HB cycles): both outputs 0. At end: if bits sent < 32, shift and go to BIT_ON with the next bit; else go to GAP.
  - GAP (8*HB cycles = 4 bit times): both outputs 0. At end go to IDLE; rdy_o=1 and busy_o=0 on that edge.
- Timing: accept-to-rdy_o re-assert is exactly 72*HB cycles. Back-to-back words: a vld_i held high is accepted on the first cycle rdy_o=1, so the first HI/LO of the next word starts 72*HB+1 cycles after the previous accept.
- Invariants: txa_o and txb_o are never both 1. Both outputs are registered (no combinational path from inputs). Bit counter is 5 bits plus a terminal flag; there is no wrap into a 33rd bit.

Test Plan:
1. Reset hold and release: rst_i=0 for 5 cycles, then 1 with vld_i=0 -> txa_o=txb_o=0, rdy_o=1, busy_o=0 throughout. Async check: assert rst_i mid BIT_ON -> outputs 0 before the next clock edge.
2. High speed, CLOCK_KHZ=100000, spd_i=1, par_en_i=0, dat_i=32'h0000_0001:
   - bit0 gives txa_o=1 for 500 cycles, then null for 500 cycles.
   - bits 1..31 give txb_o=1 pulses of 500 cycles each.
   - rdy_o returns exactly 36000 cycles after accept.
3. Low speed, spd_i=0, dat_i=32'hAAAA_AAAA -> alternating txb/txa pulses of 4000 cycles with 4000-cycle nulls; rdy_o returns at 288000 cycles. Toggling spd_i mid-word changes nothing.
4. Parity:
   - dat_i=32'h0000_0003 with par_en_i=1 -> bit31 sent as 1 (txa_o pulse in the last slot).
   - dat_i=32'h0000_0007 with par_en_i=1 -> bit31 sent as 0.
   - dat_i=32'h8000_0000 with par_en_i=0 -> bit31 sent as 1.
5. Back-to-back: vld_i held high with two words -> second accept occurs 36000 cycles after the first (high speed). The gap shows 4000 null cycles, and the second word's first pulse starts at cycle 36001. A third vld_i during transmission is not accepted.
6. Reset mid-word (bit 10, high speed), release, then send a new word -> the new word starts from bit0 with full timing, and no residue of the old word appears.
